// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// and presents {pc, pc+4, instr} to IF/ID through an output slot backed by a one-entry skid.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_instr_o,
  output logic        if_flush_o,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DROP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        accept;

  // Handshake: a request is accepted on a cycle with imem_req_o & imem_gnt_i; its single
  // response arrives later as one imem_rvalid_i pulse. The out slot is consumed on accept.
  assign accept = out_valid_q & ~stall_i & ~redirect_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fpc_d        = fpc_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_pc4_d    = out_pc4_q;
    out_instr_d  = out_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_pc4_d   = skid_pc4_q;
    skid_instr_d = skid_instr_q;

    if (accept) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt_i) begin
          pc_d    = pc_q + 32'd4;
          fpc_d   = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (!out_valid_q || accept) begin
            out_valid_d = 1'b1;
            out_pc_d    = fpc_q;
            out_pc4_d   = fpc_q + 32'd4;
            out_instr_d = imem_rdata_i;
            state_d     = REQ;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = fpc_q;
            skid_pc4_d   = fpc_q + 32'd4;
            skid_instr_d = imem_rdata_i;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (accept) begin
          out_valid_d  = 1'b1;
          out_pc_d     = skid_pc_q;
          out_pc4_d    = skid_pc4_q;
          out_instr_d  = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      DROP: if (imem_rvalid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; a response still in flight must be swallowed in DROP.
    if (redirect_i) begin
      pc_d         = redirect_pc_i & ~32'd3;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      unique case (state_q)
        REQ:     state_d = imem_gnt_i ? DROP : REQ;
        WAIT:    state_d = imem_rvalid_i ? REQ : DROP;
        DROP:    state_d = imem_rvalid_i ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fpc_q        <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'd0;
      out_pc4_q    <= 32'd0;
      out_instr_q  <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_pc4_q   <= 32'd0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fpc_q        <= fpc_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
      out_instr_q  <= out_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = pc_q;
  assign if_valid_o  = out_valid_q;
  assign if_pc_o     = out_pc_q;
  assign if_pc4_o    = out_pc4_q;
  assign if_instr_o  = out_valid_q ? out_instr_q : NOP_INSTR;
  assign if_flush_o  = redirect_i;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder with variable latency, an expected-instruction
// queue filled on every granted fetch and drained whenever IF/ID consumes the out slot.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        if_valid_o, if_flush_o;
  logic [31:0] if_pc_o, if_pc4_o, if_instr_o;
  logic [2:0]  dbg_state_o;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_pc4_o(if_pc4_o),
    .if_instr_o(if_instr_o), .if_flush_o(if_flush_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch;
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat = 1;
  bit          gnt_rand = 1'b0;
  bit          gnt_force = 1'b0;
  bit          prev_stall, prev_redirect, prev_valid;
  logic [31:0] prev_pc, prev_pc4, prev_instr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, update the model, cross the edge.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] tgt);
    logic [63:0] e;
    bit acc;
    @(negedge clk);
    stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'hDEAD_BEEF;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_addr ^ 32'h0000_00A5;
      end else mem_cnt--;
    end
    imem_gnt_i = gnt_force ? 1'b1 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    check("flush", 32'(if_flush_o), 32'(rd));
    if (!if_valid_o) check("nop_instr", if_instr_o, NOP);
    if (prev_redirect) check("valid_after_redirect", 32'(if_valid_o), 32'd0);
    if (prev_stall && prev_valid && !prev_redirect) begin
      check("stall_valid", 32'(if_valid_o), 32'd1);
      check("stall_pc", if_pc_o, prev_pc);
      check("stall_pc4", if_pc4_o, prev_pc4);
      check("stall_instr", if_instr_o, prev_instr);
    end
    if (imem_req_o && (mem_pend || exp_q.size() >= 2)) check("req_blocked", 32'(imem_req_o), 32'd0);
    acc = if_valid_o && !st && !rd;
    if (acc) begin
      if (exp_q.size() == 0) check("unexpected_output", if_pc_o, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("out_pc", if_pc_o, e[63:32]);
        check("out_pc4", if_pc4_o, e[63:32] + 32'd4);
        check("out_instr", if_instr_o, e[31:0]);
      end
    end
    if (imem_rvalid_i) mem_pend = 1'b0;
    if (imem_req_o && imem_gnt_i) begin
      mem_pend = 1'b1; mem_cnt = lat - 1; mem_addr = imem_addr_o;
      if (!rd) begin
        check("fetch_addr", imem_addr_o, exp_fetch);
        exp_q.push_back({exp_fetch, exp_fetch ^ 32'h0000_00A5});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (rd) begin
      exp_q.delete();
      exp_fetch = tgt & ~32'd3;
    end
    prev_stall = st; prev_redirect = rd; prev_valid = if_valid_o;
    prev_pc = if_pc_o; prev_pc4 = if_pc4_o; prev_instr = if_instr_o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    #1;
    check("rst_valid", 32'(if_valid_o), 32'd0);
    check("rst_instr", if_instr_o, NOP);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_pc4", if_pc4_o, 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    mem_pend = 1'b0;
    exp_q.delete();
    exp_fetch = 32'h0000_0000;
    prev_stall = 1'b0; prev_redirect = 1'b0; prev_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_req", 32'(imem_req_o), 32'd0);
    @(posedge clk);
    #1;
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", imem_addr_o, 32'h0000_0000);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!if_valid_o && n < 20) begin cycle(1'b0, 1'b0, 32'd0); n++; end
    if (!if_valid_o) check(tag, 32'(if_valid_o), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    do_reset();

    // Streaming fetch with a 1-cycle memory, including a reset in the middle.
    lat = 1;
    repeat (6) cycle(1'b0, 1'b0, 32'd0);
    do_reset();
    repeat (12) cycle(1'b0, 1'b0, 32'd0);

    // Stall with an instruction in flight: skid fills, outputs frozen.
    wait_valid("timeout_stall");
    repeat (4) cycle(1'b1, 1'b0, 32'd0);
    repeat (6) cycle(1'b0, 1'b0, 32'd0);

    // Redirect while waiting on a slow response.
    lat = 2;
    begin
      int n;
      n = 0;
      while (!(mem_pend && mem_cnt != 0) && n < 20) begin cycle(1'b0, 1'b0, 32'd0); n++; end
      check("wait_window", 32'(mem_pend && mem_cnt != 0), 32'd1);
    end
    cycle(1'b0, 1'b1, 32'h0000_0100);
    repeat (8) cycle(1'b0, 1'b0, 32'd0);

    // Redirect coinciding with a grant, then redirect together with stall.
    lat = 1;
    begin
      int n;
      n = 0;
      while (!imem_req_o && n < 20) begin cycle(1'b0, 1'b0, 32'd0); n++; end
      check("req_window", 32'(imem_req_o), 32'd1);
    end
    gnt_force = 1'b1;
    cycle(1'b0, 1'b1, 32'h0000_0200);
    gnt_force = 1'b0;
    repeat (6) cycle(1'b0, 1'b0, 32'd0);
    wait_valid("timeout_redir_stall");
    cycle(1'b1, 1'b1, 32'h0000_0300);
    repeat (6) cycle(1'b0, 1'b0, 32'd0);

    // Misaligned target near the top of the address space: wraps to 0.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (10) cycle(1'b0, 1'b0, 32'd0);

    // Random mix of grants, latencies, stalls and redirects.
    gnt_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 3);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom);
    end
    gnt_rand = 1'b0;
    repeat (10) cycle(1'b0, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
